// File: rtl/mem_arbiter_pkg.sv
// Shared sizing defaults and FSM state encoding for the memory arbiter slice.
package mem_arbiter_pkg;

   localparam int PROC_COUNT = 4;
   localparam int BUS_W      = 128;
   localparam int ADDR_W     = 16;
   localparam int MEM_LAT    = 2;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_ADDR,
      RD_WAIT,
      WR
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [PTR_W-1:0] idx
);

   always_comb begin
      int               pos;
      logic             found;
      logic [PTR_W-1:0] sel;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      pos    = 0;
      sel    = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         sel = PTR_W'(pos);
         if (!found && req[sel]) begin
            found       = 1'b1;
            onehot[sel] = 1'b1;
            idx         = sel;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the shared memory port; one transaction at a time,
// read data broadcast back with a one-hot valid to the requester.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int PROC_COUNT = mem_arbiter_pkg::PROC_COUNT,
   parameter int BUS_W      = mem_arbiter_pkg::BUS_W,
   parameter int ADDR_W     = mem_arbiter_pkg::ADDR_W,
   parameter int MEM_LAT    = mem_arbiter_pkg::MEM_LAT
) (
   input  logic                              i_clk,
   input  logic                              i_rstn,
   input  logic [PROC_COUNT-1:0]             i_req_rd,
   input  logic [PROC_COUNT-1:0]             i_req_wr,
   input  logic [PROC_COUNT-1:0]             i_wr_en,
   input  logic [PROC_COUNT-1:0][ADDR_W-1:0] i_addr,
   input  logic [PROC_COUNT-1:0][BUS_W-1:0]  i_wdata,
   input  logic [PROC_COUNT-1:0][2:0]        i_wr_size,
   output logic [PROC_COUNT-1:0]             o_grant_rd,
   output logic [PROC_COUNT-1:0]             o_grant_wr,
   output logic [PROC_COUNT-1:0]             o_valid,
   output logic [BUS_W-1:0]                  o_data,
   output logic                              o_mem_en,
   output logic                              o_mem_we,
   output logic [ADDR_W-1:0]                 o_mem_addr,
   output logic [BUS_W-1:0]                  o_mem_wdata,
   output logic [2:0]                        o_mem_wsize,
   input  logic [BUS_W-1:0]                  i_mem_rdata
);

   localparam int PTR_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   arb_state_t state, next_state;

   logic [PTR_W-1:0]      ptr, ptr_nxt;
   logic [PTR_W-1:0]      cur_idx, idx_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [PROC_COUNT-1:0] req;
   logic [PROC_COUNT-1:0] pick_onehot;
   logic [PTR_W-1:0]      pick_idx;

   logic [PROC_COUNT-1:0] grant_rd_nxt, grant_wr_nxt, valid_nxt;
   logic [BUS_W-1:0]      data_nxt, mem_wdata_nxt;
   logic                  mem_en_nxt, mem_we_nxt;
   logic [ADDR_W-1:0]     mem_addr_nxt;
   logic [2:0]            mem_wsize_nxt;

   assign req = i_req_rd | i_req_wr;

   rr_picker #(
      .N     (PROC_COUNT),
      .PTR_W (PTR_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
      if (i == PTR_W'(PROC_COUNT - 1)) return '0;
      return i + PTR_W'(1);
   endfunction

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|req) next_state = i_req_rd[pick_idx] ? RD_ADDR : WR;
         RD_ADDR: next_state = RD_WAIT;
         RD_WAIT: if (cnt == '0) next_state = IDLE;
         WR:      if (i_wr_en[cur_idx]) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Every output is computed here one cycle ahead and then registered below.
   always_comb begin
      grant_rd_nxt  = o_grant_rd;
      grant_wr_nxt  = o_grant_wr;
      valid_nxt     = '0;
      data_nxt      = o_data;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = o_mem_addr;
      mem_wdata_nxt = o_mem_wdata;
      mem_wsize_nxt = o_mem_wsize;
      ptr_nxt       = ptr;
      idx_nxt       = cur_idx;
      cnt_nxt       = cnt;
      case (state)
         IDLE: begin
            if (|req) begin
               idx_nxt = pick_idx;
               if (i_req_rd[pick_idx]) grant_rd_nxt = pick_onehot;
               else                    grant_wr_nxt = pick_onehot;
            end
         end
         RD_ADDR: begin
            mem_en_nxt   = 1'b1;
            mem_addr_nxt = i_addr[cur_idx];
            cnt_nxt      = CNT_W'(MEM_LAT);
         end
         RD_WAIT: begin
            if (cnt == '0) begin
               data_nxt     = i_mem_rdata;
               valid_nxt    = o_grant_rd;
               grant_rd_nxt = '0;
               ptr_nxt      = wrap_inc(cur_idx);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         WR: begin
            if (i_wr_en[cur_idx]) begin
               mem_en_nxt    = 1'b1;
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = i_addr[cur_idx];
               mem_wdata_nxt = i_wdata[cur_idx];
               mem_wsize_nxt = i_wr_size[cur_idx];
               grant_wr_nxt  = '0;
               ptr_nxt       = wrap_inc(cur_idx);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_grant_rd  <= '0;
         o_grant_wr  <= '0;
         o_valid     <= '0;
         o_data      <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_wsize <= '0;
         ptr         <= '0;
         cur_idx     <= '0;
         cnt         <= '0;
      end else begin
         o_grant_rd  <= grant_rd_nxt;
         o_grant_wr  <= grant_wr_nxt;
         o_valid     <= valid_nxt;
         o_data      <= data_nxt;
         o_mem_en    <= mem_en_nxt;
         o_mem_we    <= mem_we_nxt;
         o_mem_addr  <= mem_addr_nxt;
         o_mem_wdata <= mem_wdata_nxt;
         o_mem_wsize <= mem_wsize_nxt;
         ptr         <= ptr_nxt;
         cur_idx     <= idx_nxt;
         cnt         <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: processor and memory models plus queues of
// expected grants, memory strobes and read returns.
module tb_mem_arbiter;

   localparam int NP      = 4;
   localparam int BW      = 128;
   localparam int AW      = 16;
   localparam int MEM_LAT = 2;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [BW-1:0] wdata;
      logic [2:0]    wsize;
   } mem_op_t;

   typedef logic [NP:0]      grant_t;
   typedef logic [NP+BW-1:0] valid_t;

   logic                      i_clk;
   logic                      i_rstn;
   logic [NP-1:0]             i_req_rd;
   logic [NP-1:0]             i_req_wr;
   logic [NP-1:0]             i_wr_en;
   logic [NP-1:0][AW-1:0]     i_addr;
   logic [NP-1:0][BW-1:0]     i_wdata;
   logic [NP-1:0][2:0]        i_wr_size;
   logic [NP-1:0]             o_grant_rd;
   logic [NP-1:0]             o_grant_wr;
   logic [NP-1:0]             o_valid;
   logic [BW-1:0]             o_data;
   logic                      o_mem_en;
   logic                      o_mem_we;
   logic [AW-1:0]             o_mem_addr;
   logic [BW-1:0]             o_mem_wdata;
   logic [2:0]                o_mem_wsize;
   logic [BW-1:0]             i_mem_rdata;

   logic [NP-1:0][AW-1:0]     rd_addr;
   logic [NP-1:0][AW-1:0]     wr_addr;
   logic [NP-1:0][BW-1:0]     wr_data;
   logic [NP-1:0][2:0]        wr_size;
   int                        wr_delay [NP];
   int                        wr_wait  [NP];
   logic [NP-1:0]             proc_wr_en;
   logic [NP-1:0]             spurious_wr_en;
   logic                      hold_req;

   grant_t                    exp_grant [$];
   mem_op_t                   exp_mem   [$];
   valid_t                    exp_valid [$];

   int                        checks;
   int                        failures;
   int                        cycle;
   int                        rd_due;
   int                        rd_en_due;
   int                        valid_due;
   int                        wr_strobe_cycle;
   logic [AW-1:0]             rd_mem_addr;
   logic [NP-1:0]             prev_grant;
   logic [BW-1:0]             last_data;

   mem_arbiter #(
      .PROC_COUNT (NP),
      .BUS_W      (BW),
      .ADDR_W     (AW),
      .MEM_LAT    (MEM_LAT)
   ) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_req_rd    (i_req_rd),
      .i_req_wr    (i_req_wr),
      .i_wr_en     (i_wr_en),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_wr_size   (i_wr_size),
      .o_grant_rd  (o_grant_rd),
      .o_grant_wr  (o_grant_wr),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_mem_en    (o_mem_en),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_wsize (o_mem_wsize),
      .i_mem_rdata (i_mem_rdata)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Write payload is only presented while the strobe is up, so early sampling shows.
   assign i_wr_en = proc_wr_en | spurious_wr_en;
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         i_addr[i]    = proc_wr_en[i] ? wr_addr[i] : rd_addr[i];
         i_wdata[i]   = proc_wr_en[i] ? wr_data[i] : ~wr_data[i];
         i_wr_size[i] = proc_wr_en[i] ? wr_size[i] : ~wr_size[i];
      end
   end

   function automatic logic [BW-1:0] mem_val(input logic [AW-1:0] a);
      return {a - 16'h0040, 96'h0, a ^ 16'h00E5};
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic expectRead(input int idx, input bit with_valid);
      mem_op_t m;
      m       = '0;
      m.addr  = rd_addr[idx];
      exp_grant.push_back({1'b0, NP'(1) << idx});
      exp_mem.push_back(m);
      if (with_valid) exp_valid.push_back({NP'(1) << idx, mem_val(rd_addr[idx])});
   endtask

   task automatic expectWrite(input int idx);
      mem_op_t m;
      m.we    = 1'b1;
      m.addr  = wr_addr[idx];
      m.wdata = wr_data[idx];
      m.wsize = wr_size[idx];
      exp_grant.push_back({1'b1, NP'(1) << idx});
      exp_mem.push_back(m);
   endtask

   task automatic applyStimulus(input logic [NP-1:0] rd_mask, input logic [NP-1:0] wr_mask);
      i_req_rd = i_req_rd | rd_mask;
      i_req_wr = i_req_wr | wr_mask;
   endtask

   // One cycle: monitor outputs, run the processor and memory models, drive inputs.
   task automatic tick();
      logic [NP-1:0] any_grant;
      mem_op_t       m;
      valid_t        v;
      grant_t        g;
      @(negedge i_clk);
      cycle++;
      if (!i_rstn) begin
         prev_grant = '0;
         last_data  = '0;
         rd_due     = -1;
         proc_wr_en = '0;
         for (int i = 0; i < NP; i++) wr_wait[i] = 0;
      end else begin
         any_grant = o_grant_rd | o_grant_wr;
         if (any_grant != '0) begin
            checkOutput("one_grant",
                        {255'd0, ($countones(any_grant) == 1) && !((|o_grant_rd) && (|o_grant_wr))}, 1);
            if (prev_grant == '0) begin
               if (exp_grant.size() == 0) begin
                  checkOutput("grant_unexpected", {|o_grant_wr, any_grant}, 0);
               end else begin
                  g = exp_grant.pop_front();
                  checkOutput("grant_order", {|o_grant_wr, any_grant}, g);
               end
               if (o_grant_rd != '0) rd_en_due = cycle + 1;
            end
         end
         prev_grant = any_grant;

         if (o_mem_en) begin
            if (exp_mem.size() == 0) begin
               checkOutput("mem_unexpected", {o_mem_we, o_mem_addr}, 0);
            end else begin
               m = exp_mem.pop_front();
               if (!m.we) begin
                  checkOutput("rd_mem", {o_mem_we, o_mem_addr}, {m.we, m.addr});
                  checkOutput("rd_en_time", cycle, rd_en_due);
                  rd_due      = cycle + MEM_LAT;
                  valid_due   = cycle + MEM_LAT + 1;
                  rd_mem_addr = o_mem_addr;
               end else begin
                  checkOutput("wr_mem", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wsize}, m);
                  checkOutput("wr_en_time", cycle, wr_strobe_cycle + 1);
                  checkOutput("wr_grant_drop", o_grant_wr, 0);
               end
            end
         end

         if (o_valid != '0) begin
            if (exp_valid.size() == 0) begin
               checkOutput("valid_unexpected", o_valid, 0);
            end else begin
               v = exp_valid.pop_front();
               checkOutput("rd_valid", {o_valid, o_data}, v);
               checkOutput("valid_time", cycle, valid_due);
            end
            last_data = o_data;
         end else begin
            checkOutput("data_hold", o_data, last_data);
         end

         for (int i = 0; i < NP; i++) begin
            if (o_grant_rd[i] && !hold_req) i_req_rd[i] = 1'b0;
            if (o_grant_wr[i]) begin
               i_req_wr[i] = 1'b0;
               if (wr_wait[i] == wr_delay[i]) begin
                  proc_wr_en[i]   = 1'b1;
                  wr_strobe_cycle = cycle;
               end else begin
                  proc_wr_en[i] = 1'b0;
                  wr_wait[i]++;
               end
            end else begin
               proc_wr_en[i] = 1'b0;
               wr_wait[i]    = 0;
            end
         end
      end
      i_mem_rdata = (cycle == rd_due) ? mem_val(rd_mem_addr)
                                      : {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (n < budget && !(exp_grant.size() == 0 && exp_mem.size() == 0 && exp_valid.size() == 0 &&
                             (o_grant_rd | o_grant_wr) == '0 && !o_mem_en)) begin
         tick();
         n++;
      end
      if (n >= budget) checkOutput("drain_timeout", n, 0);
      repeat (3) tick();
   endtask

   initial begin
      int n;
      checks          = 0;
      failures        = 0;
      cycle           = 0;
      rd_due          = -1;
      rd_en_due       = -1;
      valid_due       = -1;
      wr_strobe_cycle = -10;
      rd_mem_addr     = '0;
      prev_grant      = '0;
      last_data       = '0;
      hold_req        = 1'b0;
      i_req_rd        = '0;
      i_req_wr        = '0;
      proc_wr_en      = '0;
      spurious_wr_en  = '0;
      i_mem_rdata     = '0;
      rd_addr[0] = 16'h0100; rd_addr[1] = 16'h0210; rd_addr[2] = 16'h0040; rd_addr[3] = 16'h03F0;
      for (int i = 0; i < NP; i++) begin
         wr_addr[i]  = 16'h0800 + AW'(i);
         wr_data[i]  = '0;
         wr_size[i]  = 3'd0;
         wr_delay[i] = 0;
         wr_wait[i]  = 0;
      end

      i_rstn = 1'b1;
      #2 i_rstn = 1'b0;
      repeat (3) tick();
      checkOutput("rst_grant_rd", o_grant_rd, 0);
      checkOutput("rst_grant_wr", o_grant_wr, 0);
      checkOutput("rst_valid", o_valid, 0);
      checkOutput("rst_data", o_data, 0);
      checkOutput("rst_mem", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wsize}, 0);
      i_rstn = 1'b1;
      repeat (2) tick();

      $display("[TB] single read from processor 2");
      expectRead(2, 1'b1);
      applyStimulus(4'b0100, 4'b0000);
      drain(40);

      $display("[TB] reset during read wait");
      expectRead(1, 1'b0);
      applyStimulus(4'b0010, 4'b0000);
      n = 0;
      while (n < 20 && exp_mem.size() != 0) begin
         tick();
         n++;
      end
      if (n >= 20) checkOutput("rst_read_timeout", n, 0);
      tick();
      #3 i_rstn = 1'b0;
      #1;
      checkOutput("rst_mid_grant", {o_grant_rd, o_grant_wr}, 0);
      checkOutput("rst_mid_mem", {o_mem_en, o_mem_addr}, 0);
      checkOutput("rst_mid_data", {o_valid, o_data}, 0);
      repeat (2) tick();
      i_rstn = 1'b1;
      repeat (8) tick();

      $display("[TB] round robin over all readers");
      expectRead(0, 1'b1);
      expectRead(1, 1'b1);
      expectRead(2, 1'b1);
      expectRead(3, 1'b1);
      expectRead(0, 1'b1);
      hold_req = 1'b1;
      applyStimulus(4'b1111, 4'b0000);
      n = 0;
      while (n < 100 && exp_grant.size() != 0) begin
         tick();
         n++;
      end
      if (n >= 100) checkOutput("rr_timeout", n, 0);
      i_req_rd = '0;
      hold_req = 1'b0;
      drain(40);

      $display("[TB] write with late strobe and stray strobe");
      wr_addr[1]  = 16'h0010;
      wr_data[1]  = 128'h1234;
      wr_size[1]  = 3'd4;
      wr_delay[1] = 3;
      expectWrite(1);
      spurious_wr_en = 4'b0001;
      applyStimulus(4'b0000, 4'b0010);
      drain(40);
      spurious_wr_en = '0;

      $display("[TB] read priority on a dual requester");
      wr_addr[1]  = 16'h0020;
      wr_data[1]  = 128'hCAFE;
      wr_size[1]  = 3'd2;
      wr_delay[1] = 0;
      wr_addr[3]  = 16'h0030;
      wr_data[3]  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      wr_size[3]  = 3'd7;
      wr_delay[3] = 1;
      expectRead(3, 1'b1);
      expectRead(0, 1'b1);
      expectWrite(1);
      expectWrite(3);
      applyStimulus(4'b1001, 4'b1010);
      drain(80);

      $display("[TB] withdrawn read still completes");
      expectRead(0, 1'b1);
      applyStimulus(4'b0001, 4'b0000);
      drain(40);

      checkOutput("left_grants", exp_grant.size(), 0);
      checkOutput("left_mem", exp_mem.size(), 0);
      checkOutput("left_valid", exp_valid.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
